// File: rtl/countdown_ctrl.sv
// ============================================================================
// Module   : countdown_ctrl
// Brief    : MM:SS countdown sequencer (IDLE/SET/RUN/PAUSE/DONE) that drives
//            BCD digits and per-digit blink/blank enables for a 4-digit display.
//            Optional macro: LEADING_ZERO_BLANK_EN (blank a zero minute-tens digit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_ctrl #(
    parameter int INIT_MIN = 5,
    parameter int INIT_SEC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       blink_tick,
    input  logic       start_stop,
    input  logic       set_mode,
    input  logic       inc,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic       enable_3,
    output logic       enable_2,
    output logic       enable_1,
    output logic       enable_0,
    output logic       running,
    output logic       alarm
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic       c_SEL_MIN   = 1'b0;
    localparam logic       c_SEL_SEC   = 1'b1;
    localparam logic [3:0] c_MAX_MT    = 4'd9;
    localparam logic [3:0] c_MAX_ST    = 4'd5;
    localparam logic [3:0] c_INIT_MT   = 4'(INIT_MIN / 10);
    localparam logic [3:0] c_INIT_MO   = 4'(INIT_MIN % 10);
    localparam logic [3:0] c_INIT_ST   = 4'(INIT_SEC / 10);
    localparam logic [3:0] c_INIT_SO   = 4'(INIT_SEC % 10);
    localparam logic [15:0] c_INIT_TIME = {c_INIT_MT, c_INIT_MO, c_INIT_ST, c_INIT_SO};

    state_t      r_state;
    logic [15:0] r_time;
    logic [15:0] r_preset;
    logic        r_sel;
    logic        r_blink;

    state_t      w_nxt_state;
    logic [15:0] w_nxt_time;
    logic [15:0] w_nxt_preset;
    logic        w_nxt_sel;
    logic        w_nxt_blink;
    logic [3:0]  w_nxt_en;
    logic        w_time_zero;
    logic [15:0] w_time_dec;

    // Two-digit BCD field increment; ones always wrap at 9, tens at max_tens.
    function automatic logic [7:0] f_field_inc(input logic [7:0] f, input logic [3:0] max_tens);
        logic [7:0] r;
        if (f[3:0] == 4'd9) begin
            if (f[7:4] == max_tens) r = 8'h00;
            else                    r = {f[7:4] + 4'd1, 4'd0};
        end else begin
            r = {f[7:4], f[3:0] + 4'd1};
        end
        return r;
    endfunction

    // One-second BCD decrement across the whole MM:SS value.
    function automatic logic [15:0] f_time_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = c_MAX_ST;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign w_time_zero = (r_time == 16'h0000);
    assign w_time_dec  = f_time_dec(r_time);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_time   = r_time;
        w_nxt_preset = r_preset;
        w_nxt_sel    = r_sel;
        w_nxt_blink  = r_blink ^ blink_tick;
        case (r_state)
            S_IDLE: begin
                if (set_mode) begin
                    w_nxt_state = S_SET;
                    w_nxt_sel   = c_SEL_MIN;
                    w_nxt_blink = 1'b1;
                end else if (start_stop && !w_time_zero) begin
                    w_nxt_state = S_RUN;
                end
            end
            S_RUN: begin
                if (start_stop) begin
                    w_nxt_state = S_PAUSE;
                end else if (tick) begin
                    w_nxt_time = w_time_dec;
                    if (w_time_dec == 16'h0000) begin
                        w_nxt_state = S_DONE;
                        w_nxt_blink = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (set_mode) begin
                    w_nxt_state = S_SET;
                    w_nxt_sel   = c_SEL_MIN;
                    w_nxt_blink = 1'b1;
                end else if (start_stop) begin
                    w_nxt_state = S_RUN;
                end
            end
            S_SET: begin
                if (set_mode) begin
                    if (r_sel == c_SEL_MIN) begin
                        w_nxt_sel = c_SEL_SEC;
                    end else begin
                        w_nxt_state  = S_IDLE;
                        w_nxt_preset = r_time;
                    end
                end else if (inc) begin
                    w_nxt_blink = 1'b1;
                    if (r_sel == c_SEL_MIN)
                        w_nxt_time[15:8] = f_field_inc(r_time[15:8], c_MAX_MT);
                    else
                        w_nxt_time[7:0]  = f_field_inc(r_time[7:0], c_MAX_ST);
                end
            end
            S_DONE: begin
                if (start_stop || set_mode) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_time  = r_preset;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Enables are derived from next-state values so they register alongside the digits.
    always_comb begin
        w_nxt_en = 4'hF;
        case (w_nxt_state)
            S_SET: begin
                if (w_nxt_sel == c_SEL_MIN) w_nxt_en = {w_nxt_blink, w_nxt_blink, 2'b11};
                else                        w_nxt_en = {2'b11, w_nxt_blink, w_nxt_blink};
            end
            S_DONE: begin
                w_nxt_en = {4{w_nxt_blink}};
            end
            default: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (w_nxt_time[15:12] == 4'd0) w_nxt_en[3] = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_time   <= c_INIT_TIME;
            r_preset <= c_INIT_TIME;
            r_sel    <= c_SEL_MIN;
            r_blink  <= 1'b1;
            {digit_3, digit_2, digit_1, digit_0} <= c_INIT_TIME;
`ifdef LEADING_ZERO_BLANK_EN
            {enable_3, enable_2, enable_1, enable_0} <= {(c_INIT_MT != 4'd0), 3'b111};
`else
            {enable_3, enable_2, enable_1, enable_0} <= 4'hF;
`endif
            running  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_time   <= w_nxt_time;
            r_preset <= w_nxt_preset;
            r_sel    <= w_nxt_sel;
            r_blink  <= w_nxt_blink;
            {digit_3, digit_2, digit_1, digit_0}     <= w_nxt_time;
            {enable_3, enable_2, enable_1, enable_0} <= w_nxt_en;
            running  <= (w_nxt_state == S_RUN);
            alarm    <= (w_nxt_state == S_DONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
// Testbench for countdown_ctrl: directed stimulus, per-cycle model comparison
// plus literal checkpoints. Honours LEADING_ZERO_BLANK_EN when defined.
`default_nettype none

module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, blink_tick = 1'b0, start_stop = 1'b0, set_mode = 1'b0, inc = 1'b0;
    logic [3:0] digit_3, digit_2, digit_1, digit_0;
    logic       enable_3, enable_2, enable_1, enable_0;
    logic       running, alarm;

    int n_checks = 0;
    int n_err    = 0;

    countdown_ctrl #(.INIT_MIN(5), .INIT_SEC(0)) dut (
        .clk(clk), .reset(reset), .tick(tick), .blink_tick(blink_tick),
        .start_stop(start_stop), .set_mode(set_mode), .inc(inc),
        .digit_3(digit_3), .digit_2(digit_2), .digit_1(digit_1), .digit_0(digit_0),
        .enable_3(enable_3), .enable_2(enable_2), .enable_1(enable_1), .enable_0(enable_0),
        .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Behavioural model: time kept as integer minutes/seconds.
    localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
    int m_state, m_min, m_sec, p_min, p_sec, m_sel;
    bit m_blink;
    bit m_valid = 0;

    always @(posedge clk) begin
        int total;
        bit nb;
        if (reset) begin
            m_state = M_IDLE; m_min = 5; m_sec = 0; p_min = 5; p_sec = 0;
            m_sel = 0; m_blink = 1; m_valid = 1;
        end else begin
            nb = m_blink ^ blink_tick;
            case (m_state)
                M_IDLE: if (set_mode) begin m_state = M_SET; m_sel = 0; nb = 1; end
                        else if (start_stop && (m_min * 60 + m_sec) != 0) m_state = M_RUN;
                M_RUN: if (start_stop) m_state = M_PAUSE;
                       else if (tick) begin
                           total = m_min * 60 + m_sec - 1;
                           m_min = total / 60; m_sec = total % 60;
                           if (total == 0) begin m_state = M_DONE; nb = 1; end
                       end
                M_PAUSE: if (set_mode) begin m_state = M_SET; m_sel = 0; nb = 1; end
                         else if (start_stop) m_state = M_RUN;
                M_SET: if (set_mode) begin
                           if (m_sel == 0) m_sel = 1;
                           else begin m_state = M_IDLE; p_min = m_min; p_sec = m_sec; end
                       end else if (inc) begin
                           nb = 1;
                           if (m_sel == 0) m_min = (m_min + 1) % 100;
                           else            m_sec = (m_sec + 1) % 60;
                       end
                default: if (start_stop || set_mode) begin
                             m_state = M_IDLE; m_min = p_min; m_sec = p_sec;
                         end
            endcase
            m_blink = nb;
        end
    end

    function automatic logic [3:0] model_en();
        logic [3:0] e;
        case (m_state)
            M_SET:  e = (m_sel == 0) ? {m_blink, m_blink, 2'b11} : {2'b11, m_blink, m_blink};
            M_DONE: e = {4{m_blink}};
            default: begin
                e = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
                if (m_min / 10 == 0) e[3] = 1'b0;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("digits", {digit_3, digit_2, digit_1, digit_0},
                {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)});
            chk("enables", {enable_3, enable_2, enable_1, enable_0}, model_en());
            chk("running", running, m_state == M_RUN);
            chk("alarm", alarm, m_state == M_DONE);
        end
    end

    // Apply one cycle of inputs starting at a negedge; returns at the next negedge.
    task automatic cyc(input bit t, input bit bt, input bit ss, input bit sm, input bit in);
        tick = t; blink_tick = bt; start_stop = ss; set_mode = sm; inc = in;
        @(posedge clk);
        @(negedge clk);
        tick = 0; blink_tick = 0; start_stop = 0; set_mode = 0; inc = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(0, 0, 0, 0, 0);
        reset = 0;
    endtask

    function automatic logic [15:0] dig();
        return {digit_3, digit_2, digit_1, digit_0};
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        do_reset();
        chk("lit_reset_digits", dig(), 16'h0500);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lit_reset_en", {enable_3, enable_2, enable_1, enable_0}, 4'h7);
`else
        chk("lit_reset_en", {enable_3, enable_2, enable_1, enable_0}, 4'hF);
`endif
        chk("lit_reset_run", {running, alarm}, 2'b00);

        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("lit_first_tick", dig(), 16'h0459);
        chk("lit_running", running, 1'b1);

        // Pause with simultaneous tick, ticks ignored, then resume
        cyc(1, 0, 1, 0, 0);
        chk("lit_pause_hold", dig(), 16'h0459);
        chk("lit_paused", running, 1'b0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("lit_pause_ticks", dig(), 16'h0459);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("lit_resume", dig(), 16'h0458);
        cyc(0, 0, 0, 1, 1);
        chk("lit_run_ignores", {15'd0, running, dig()}, {15'd0, 1'b1, 16'h0458});

        // Pause then set_mode+start_stop -> SET; minute wrap 99->00
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        for (int i = 0; i < 95; i++) cyc(0, (i % 7) == 3, 0, 0, 1);
        chk("lit_min99", dig(), 16'h9958);
        cyc(0, 0, 0, 0, 1);
        chk("lit_min_wrap", dig(), 16'h0058);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        chk("lit_inc_dropped", dig(), 16'h1058);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("lit_sec_wrap", dig(), 16'h1000);
        cyc(0, 0, 0, 1, 0);

        // Run 10:00 down to DONE
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("lit_borrow", dig(), 16'h0959);
        for (int i = 0; i < 598; i++) cyc(1, 0, 0, 0, 0);
        chk("lit_0001", dig(), 16'h0001);
        cyc(1, 0, 0, 0, 0);
        chk("lit_done", {alarm, running, dig()}, {2'b10, 16'h0000});
        chk("lit_done_en", {enable_3, enable_2, enable_1, enable_0}, 4'hF);
        cyc(0, 1, 0, 0, 0);
        chk("lit_done_blink", {enable_3, enable_2, enable_1, enable_0}, 4'h0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("lit_reload", {alarm, dig()}, {1'b0, 16'h1000});

        // Program 00:30 preset and verify it reloads after DONE
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 90; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++) cyc(0, (i % 5) == 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        chk("lit_set_0030", dig(), 16'h0030);
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 0);
        chk("lit_done2", alarm, 1'b1);
        cyc(0, 0, 1, 1, 0);
        chk("lit_preset_0030", dig(), 16'h0030);

        // Zero time: start_stop ignored in IDLE
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        chk("lit_zero_idle", {running, dig()}, {1'b0, 16'h0000});

        // Reset mid-run at 03:17
        do_reset();
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 103; i++) cyc(1, 0, 0, 0, 0);
        chk("lit_0317", dig(), 16'h0317);
        do_reset();
        chk("lit_mid_reset", {running, dig()}, {1'b0, 16'h0500});
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        chk("lit_set_blink", {enable_3, enable_2, enable_1, enable_0}, 4'h3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
